// File: rtl/ccp_fill_ctrl_if.sv
// Bus bundle for the cache fill controller: the fill request from the miss
// handler, the tag/data array write ports and the fill-complete notification.
// The master modport is the controller's view; slave is the surrounding logic.
interface ccp_fill_ctrl_if #(
  parameter int N_WAYS  = 4,
  parameter int SET_W   = 9,
  parameter int TAG_W   = 24,
  parameter int STATE_W = 2,
  parameter int N_BEATS = 4,
  parameter int DATA_W  = 128
);
  localparam int WAY_W  = $clog2(N_WAYS);
  localparam int BEAT_W = $clog2(N_BEATS);

  logic               fill_req_valid;
  logic               fill_req_ready;
  logic [WAY_W-1:0]   fill_req_way;
  logic [SET_W-1:0]   fill_req_index;
  logic [TAG_W-1:0]   fill_req_tag;
  logic [STATE_W-1:0] fill_req_state;

  logic               tag_wr_valid;
  logic               tag_wr_ready;
  logic [WAY_W-1:0]   tag_wr_way;
  logic [SET_W-1:0]   tag_wr_index;
  logic [TAG_W-1:0]   tag_wr_tag;
  logic [STATE_W-1:0] tag_wr_state;

  logic               fill_data_valid;
  logic               fill_data_ready;
  logic [DATA_W-1:0]  fill_data;

  logic               data_wr_valid;
  logic               data_wr_ready;
  logic [WAY_W-1:0]   data_wr_way;
  logic [SET_W-1:0]   data_wr_index;
  logic [BEAT_W-1:0]  data_wr_beat;
  logic [DATA_W-1:0]  data_wr_data;

  logic               fill_done_valid;
  logic               fill_done_ready;
  logic [WAY_W-1:0]   fill_done_way;

  modport master (
    input  fill_req_valid, fill_req_way, fill_req_index, fill_req_tag, fill_req_state,
    output fill_req_ready,
    output tag_wr_valid, tag_wr_way, tag_wr_index, tag_wr_tag, tag_wr_state,
    input  tag_wr_ready,
    input  fill_data_valid, fill_data,
    output fill_data_ready,
    output data_wr_valid, data_wr_way, data_wr_index, data_wr_beat, data_wr_data,
    input  data_wr_ready,
    output fill_done_valid, fill_done_way,
    input  fill_done_ready
  );

  modport slave (
    output fill_req_valid, fill_req_way, fill_req_index, fill_req_tag, fill_req_state,
    input  fill_req_ready,
    input  tag_wr_valid, tag_wr_way, tag_wr_index, tag_wr_tag, tag_wr_state,
    output tag_wr_ready,
    output fill_data_valid, fill_data,
    input  fill_data_ready,
    input  data_wr_valid, data_wr_way, data_wr_index, data_wr_beat, data_wr_data,
    output data_wr_ready,
    input  fill_done_valid, fill_done_way,
    output fill_done_ready
  );
endinterface

// File: rtl/ccp_fill_ctrl.sv
// Cache line fill controller. Accepts one fill at a time, writes the new tag
// and line state, streams the data beats straight through to the data array,
// then reports completion. Per-way pending flags tell the rest of the cache
// which way is mid-fill and which phase it is in.
module ccp_fill_ctrl #(
  parameter int N_WAYS  = 4,
  parameter int SET_W   = 9,
  parameter int TAG_W   = 24,
  parameter int STATE_W = 2,
  parameter int N_BEATS = 4,
  parameter int DATA_W  = 128
) (
  input  logic                clk,
  input  logic                reset_n,
  ccp_fill_ctrl_if.master     bus,
  output logic [N_WAYS-1:0]   fill_state_pending_o,
  output logic [N_WAYS-1:0]   fill_data_pending_o,
  output logic [N_WAYS-1:0]   fill_done_pending_o,
  output logic                fill_err_o
);
  localparam int WAY_W  = $clog2(N_WAYS);
  localparam int BEAT_W = $clog2(N_BEATS);
  localparam logic [N_WAYS-1:0] WAY0_ONEHOT = N_WAYS'(1);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(N_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    TAG_WR,
    DATA,
    DONE
  } state_t;

  state_t               state_q;
  logic [WAY_W-1:0]     way_q;
  logic [SET_W-1:0]     index_q;
  logic [TAG_W-1:0]     tag_q;
  logic [STATE_W-1:0]   line_state_q;
  logic [BEAT_W-1:0]    beat_q;
  logic [BEAT_W-1:0]    beat_d;
  logic [N_WAYS-1:0]    state_pend_q;
  logic [N_WAYS-1:0]    data_pend_q;
  logic [N_WAYS-1:0]    done_pend_q;
  logic                 err_q;

  logic                 data_hs;
  logic [N_WAYS-1:0]    req_way_onehot;
  logic [N_WAYS-1:0]    cur_way_onehot;
  logic [DATA_W-1:0]    beat_data;

  assign data_hs        = (state_q == DATA) && bus.fill_data_valid && bus.data_wr_ready;
  assign beat_d         = beat_q + BEAT_W'(1);
  assign req_way_onehot = WAY0_ONEHOT << bus.fill_req_way;
  assign cur_way_onehot = WAY0_ONEHOT << way_q;
  assign beat_data      = bus.fill_data;

  // Fill sequencer: owns the latched request, beat counter and pending flags.
  // A request with line state 0 would install an invalid line, so it is
  // refused with a one-cycle error pulse and the controller stays idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      way_q        <= '0;
      index_q      <= '0;
      tag_q        <= '0;
      line_state_q <= '0;
      beat_q       <= '0;
      state_pend_q <= '0;
      data_pend_q  <= '0;
      done_pend_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.fill_req_valid) begin
            if (bus.fill_req_state != '0) begin
              way_q        <= bus.fill_req_way;
              index_q      <= bus.fill_req_index;
              tag_q        <= bus.fill_req_tag;
              line_state_q <= bus.fill_req_state;
              beat_q       <= '0;
              state_pend_q <= state_pend_q | req_way_onehot;
              data_pend_q  <= data_pend_q | req_way_onehot;
              state_q      <= TAG_WR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        TAG_WR: begin
          if (bus.tag_wr_ready) begin
            state_pend_q <= state_pend_q & ~cur_way_onehot;
            state_q      <= DATA;
          end
        end
        DATA: begin
          if (data_hs) begin
            beat_q <= beat_d;
            if (beat_q == LAST_BEAT) begin
              data_pend_q <= data_pend_q & ~cur_way_onehot;
              done_pend_q <= done_pend_q | cur_way_onehot;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.fill_done_ready) begin
            done_pend_q <= done_pend_q & ~cur_way_onehot;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fill_req_ready  = (state_q == IDLE);

  assign bus.tag_wr_valid    = (state_q == TAG_WR);
  assign bus.tag_wr_way      = way_q;
  assign bus.tag_wr_index    = index_q;
  assign bus.tag_wr_tag      = tag_q;
  assign bus.tag_wr_state    = line_state_q;

  assign bus.data_wr_valid   = (state_q == DATA) && bus.fill_data_valid;
  assign bus.fill_data_ready = (state_q == DATA) && bus.data_wr_ready;
  assign bus.data_wr_way     = way_q;
  assign bus.data_wr_index   = index_q;
  assign bus.data_wr_beat    = beat_q;
  assign bus.data_wr_data    = beat_data;

  assign bus.fill_done_valid = (state_q == DONE);
  assign bus.fill_done_way   = way_q;

  assign fill_state_pending_o = state_pend_q;
  assign fill_data_pending_o  = data_pend_q;
  assign fill_done_pending_o  = done_pend_q;
  assign fill_err_o           = err_q;
endmodule

// File: tb/tb_ccp_fill_ctrl.sv
// Self-checking bench for ccp_fill_ctrl: directed fill scenarios followed by
// a long random-stall run compared against a transaction-level model.
module tb_ccp_fill_ctrl;
  localparam int N_WAYS  = 4;
  localparam int SET_W   = 9;
  localparam int TAG_W   = 24;
  localparam int STATE_W = 2;
  localparam int N_BEATS = 4;
  localparam int DATA_W  = 128;
  localparam int WAY_W   = $clog2(N_WAYS);
  localparam int BEAT_W  = $clog2(N_BEATS);

  logic              clk;
  logic              reset_n;
  logic [N_WAYS-1:0] state_pend;
  logic [N_WAYS-1:0] data_pend;
  logic [N_WAYS-1:0] done_pend;
  logic              fill_err;

  int checks = 0;
  int errors = 0;

  ccp_fill_ctrl_if #(
    .N_WAYS(N_WAYS), .SET_W(SET_W), .TAG_W(TAG_W),
    .STATE_W(STATE_W), .N_BEATS(N_BEATS), .DATA_W(DATA_W)
  ) bus ();

  ccp_fill_ctrl #(
    .N_WAYS(N_WAYS), .SET_W(SET_W), .TAG_W(TAG_W),
    .STATE_W(STATE_W), .N_BEATS(N_BEATS), .DATA_W(DATA_W)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .bus                  (bus),
    .fill_state_pending_o (state_pend),
    .fill_data_pending_o  (data_pend),
    .fill_done_pending_o  (done_pend),
    .fill_err_o           (fill_err)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DATA_W-1:0] rand_data();
    return DATA_W'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [N_WAYS-1:0] onehot(input logic [WAY_W-1:0] w);
    logic [N_WAYS-1:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  task automatic idle_inputs();
    bus.fill_req_valid  = 1'b0;
    bus.fill_req_way    = '0;
    bus.fill_req_index  = '0;
    bus.fill_req_tag    = '0;
    bus.fill_req_state  = '0;
    bus.tag_wr_ready    = 1'b1;
    bus.fill_data_valid = 1'b0;
    bus.fill_data       = '0;
    bus.data_wr_ready   = 1'b1;
    bus.fill_done_ready = 1'b1;
  endtask

  task automatic applyStimulus(input logic [WAY_W-1:0] way, input logic [SET_W-1:0] idx,
                               input logic [TAG_W-1:0] tag, input logic [STATE_W-1:0] st);
    bus.fill_req_valid = 1'b1;
    bus.fill_req_way   = way;
    bus.fill_req_index = idx;
    bus.fill_req_tag   = tag;
    bus.fill_req_state = st;
  endtask

  // Drives all readies high and beats valid until the done notification
  // appears (bounded); the done handshake completes on the following edge.
  task automatic run_to_idle(output bit ok, output logic [WAY_W-1:0] way);
    ok  = 1'b0;
    way = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.fill_req_valid  = 1'b0;
      bus.tag_wr_ready    = 1'b1;
      bus.data_wr_ready   = 1'b1;
      bus.fill_done_ready = 1'b1;
      bus.fill_data_valid = 1'b1;
      bus.fill_data       = rand_data();
      #1;
      if (bus.fill_done_valid) begin
        way = bus.fill_done_way;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    applyStimulus(2'd1, 9'd3, 24'h123, 2'd1);
    bus.fill_data_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (state_pend !== '0 || data_pend !== '0 || done_pend !== '0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b/%b/%b expected 0", state_pend, data_pend, done_pend);
    end
    checks++; if (fill_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_err: got %b expected 0", fill_err);
    end
    checks++; if (bus.tag_wr_valid !== 1'b0 || bus.data_wr_valid !== 1'b0 || bus.fill_done_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valids: got %b%b%b expected 000",
                         bus.tag_wr_valid, bus.data_wr_valid, bus.fill_done_valid);
    end
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (bus.fill_req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.fill_req_ready);
    end
  endtask

  task automatic test_basic_fill();
    logic [DATA_W-1:0] d;
    @(negedge clk);
    idle_inputs();
    applyStimulus(2'd2, 9'd5, 24'hABC, 2'd1);
    #1;
    checks++; if (bus.fill_req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_req_ready: got %b expected 1", bus.fill_req_ready);
    end
    @(negedge clk);
    bus.fill_req_valid = 1'b0;
    #1;
    checks++; if (bus.tag_wr_valid !== 1'b1 || bus.tag_wr_way !== 2'd2 || bus.tag_wr_index !== 9'd5 ||
                  bus.tag_wr_tag !== 24'hABC || bus.tag_wr_state !== 2'd1) begin
      errors++; $display("[TB] FAIL basic_tag_wr: got v=%b w=%0d i=%0d t=%h s=%0d expected v=1 w=2 i=5 t=abc s=1",
                         bus.tag_wr_valid, bus.tag_wr_way, bus.tag_wr_index, bus.tag_wr_tag, bus.tag_wr_state);
    end
    checks++; if (state_pend !== 4'b0100 || data_pend !== 4'b0100 || bus.fill_req_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_tag_flags: got sp=%b dp=%b rdy=%b expected 0100 0100 0",
                         state_pend, data_pend, bus.fill_req_ready);
    end
    for (int b = 0; b < N_BEATS; b++) begin
      @(negedge clk);
      d = rand_data();
      bus.fill_data_valid = 1'b1;
      bus.fill_data       = d;
      #1;
      checks++; if (bus.data_wr_valid !== 1'b1 || bus.fill_data_ready !== 1'b1 ||
                    bus.data_wr_beat !== BEAT_W'(b) || bus.data_wr_data !== d ||
                    bus.data_wr_way !== 2'd2 || bus.data_wr_index !== 9'd5) begin
        errors++; $display("[TB] FAIL basic_beat%0d: got v=%b r=%b beat=%0d w=%0d i=%0d data_ok=%b expected v=1 r=1 beat=%0d w=2 i=5 data_ok=1",
                           b, bus.data_wr_valid, bus.fill_data_ready, bus.data_wr_beat,
                           bus.data_wr_way, bus.data_wr_index, bus.data_wr_data === d, b);
      end
      checks++; if (state_pend !== 4'b0000 || data_pend !== 4'b0100 || done_pend !== 4'b0000) begin
        errors++; $display("[TB] FAIL basic_beat%0d_flags: got %b/%b/%b expected 0000/0100/0000",
                           b, state_pend, data_pend, done_pend);
      end
    end
    @(negedge clk);
    bus.fill_data_valid = 1'b0;
    #1;
    checks++; if (bus.fill_done_valid !== 1'b1 || bus.fill_done_way !== 2'd2 ||
                  done_pend !== 4'b0100 || data_pend !== 4'b0000) begin
      errors++; $display("[TB] FAIL basic_done: got v=%b w=%0d np=%b dp=%b expected v=1 w=2 np=0100 dp=0000",
                         bus.fill_done_valid, bus.fill_done_way, done_pend, data_pend);
    end
    @(negedge clk);
    #1;
    checks++; if (bus.fill_req_ready !== 1'b1 || bus.fill_done_valid !== 1'b0 || done_pend !== 4'b0000) begin
      errors++; $display("[TB] FAIL basic_back_idle: got rdy=%b dv=%b np=%b expected 1 0 0000",
                         bus.fill_req_ready, bus.fill_done_valid, done_pend);
    end
  endtask

  task automatic test_tag_stall();
    logic [SET_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [STATE_W-1:0] st;
    logic [WAY_W-1:0]   dway;
    bit                 ok;
    idx = SET_W'($urandom());
    tag = TAG_W'($urandom());
    st  = 2'd3;
    @(negedge clk);
    idle_inputs();
    bus.tag_wr_ready = 1'b0;
    applyStimulus(2'd2, idx, tag, st);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      applyStimulus(WAY_W'($urandom()), SET_W'($urandom()), TAG_W'($urandom()), 2'd1);
      bus.fill_data_valid = 1'b1;
      #1;
      checks++; if (bus.tag_wr_valid !== 1'b1 || bus.tag_wr_way !== 2'd2 || bus.tag_wr_index !== idx ||
                    bus.tag_wr_tag !== tag || bus.tag_wr_state !== st) begin
        errors++; $display("[TB] FAIL stall_payload%0d: got v=%b w=%0d i=%0d t=%h s=%0d expected v=1 w=2 i=%0d t=%h s=%0d",
                           c, bus.tag_wr_valid, bus.tag_wr_way, bus.tag_wr_index, bus.tag_wr_tag,
                           bus.tag_wr_state, idx, tag, st);
      end
      checks++; if (state_pend[2] !== 1'b1 || bus.fill_req_ready !== 1'b0 || bus.data_wr_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_flags%0d: got sp2=%b rdy=%b dv=%b expected 1 0 0",
                           c, state_pend[2], bus.fill_req_ready, bus.data_wr_valid);
      end
    end
    @(negedge clk);
    bus.fill_req_valid  = 1'b0;
    bus.fill_data_valid = 1'b0;
    bus.tag_wr_ready    = 1'b1;
    run_to_idle(ok, dway);
    checks++; if (!ok || dway !== 2'd2) begin
      errors++; $display("[TB] FAIL stall_done: got seen=%b way=%0d expected seen=1 way=2", ok, dway);
    end
  endtask

  task automatic test_reject();
    logic [WAY_W-1:0] dway;
    bit               ok;
    @(negedge clk);
    idle_inputs();
    applyStimulus(2'd1, 9'd77, 24'h55AA55, 2'd0);
    @(negedge clk);
    bus.fill_req_valid = 1'b0;
    #1;
    checks++; if (fill_err !== 1'b1) begin
      errors++; $display("[TB] FAIL reject_err_pulse: got %b expected 1", fill_err);
    end
    checks++; if (state_pend !== '0 || data_pend !== '0 || done_pend !== '0 ||
                  bus.fill_req_ready !== 1'b1 || bus.tag_wr_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reject_state: got %b/%b/%b rdy=%b tv=%b expected 0/0/0 rdy=1 tv=0",
                         state_pend, data_pend, done_pend, bus.fill_req_ready, bus.tag_wr_valid);
    end
    @(negedge clk);
    applyStimulus(2'd1, 9'd78, 24'h000ABC, 2'd3);
    #1;
    checks++; if (fill_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reject_err_width: got %b expected 0", fill_err);
    end
    @(negedge clk);
    bus.fill_req_valid = 1'b0;
    #1;
    checks++; if (bus.tag_wr_valid !== 1'b1 || state_pend !== 4'b0010 || bus.tag_wr_index !== 9'd78) begin
      errors++; $display("[TB] FAIL reject_next_accept: got tv=%b sp=%b i=%0d expected 1 0010 78",
                         bus.tag_wr_valid, state_pend, bus.tag_wr_index);
    end
    run_to_idle(ok, dway);
    checks++; if (!ok || dway !== 2'd1) begin
      errors++; $display("[TB] FAIL reject_next_done: got seen=%b way=%0d expected seen=1 way=1", ok, dway);
    end
  endtask

  task automatic test_data_toggle();
    int nb;
    @(negedge clk);
    idle_inputs();
    applyStimulus(2'd3, 9'd200, 24'hFEDCBA, 2'd2);
    @(negedge clk);
    bus.fill_req_valid = 1'b0;
    nb = 0;
    for (int i = 0; i < 16 && nb < N_BEATS; i++) begin
      @(negedge clk);
      bus.fill_data_valid = 1'b1;
      bus.fill_data       = rand_data();
      bus.data_wr_ready   = (i % 2 == 0);
      #1;
      checks++; if (bus.data_wr_valid !== 1'b1 || bus.data_wr_beat !== BEAT_W'(nb) ||
                    bus.fill_data_ready !== bus.data_wr_ready) begin
        errors++; $display("[TB] FAIL toggle_beat: got v=%b beat=%0d r=%b expected v=1 beat=%0d r=%b",
                           bus.data_wr_valid, bus.data_wr_beat, bus.fill_data_ready, nb, bus.data_wr_ready);
      end
      checks++; if (data_pend !== 4'b1000 || done_pend !== 4'b0000) begin
        errors++; $display("[TB] FAIL toggle_flags: got dp=%b np=%b expected 1000 0000 at beat %0d",
                           data_pend, done_pend, nb);
      end
      if (bus.data_wr_ready) nb++;
    end
    @(negedge clk);
    bus.fill_data_valid = 1'b1;
    bus.data_wr_ready   = 1'b1;
    #1;
    checks++; if (bus.fill_done_valid !== 1'b1 || bus.fill_done_way !== 2'd3 ||
                  data_pend !== 4'b0000 || done_pend !== 4'b1000 || bus.data_wr_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL toggle_done: got v=%b w=%0d dp=%b np=%b dv=%b expected 1 3 0000 1000 0",
                         bus.fill_done_valid, bus.fill_done_way, data_pend, done_pend, bus.data_wr_valid);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [WAY_W-1:0] dway;
    bit               ok;
    bit               done_seen;
    @(negedge clk);
    idle_inputs();
    applyStimulus(2'd3, 9'd9, 24'h111111, 2'd1);
    @(negedge clk);
    bus.fill_req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      bus.fill_data_valid = 1'b1;
      bus.fill_data       = rand_data();
    end
    @(negedge clk);
    #1;
    checks++; if (bus.data_wr_beat !== 2'd2 || bus.data_wr_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_at_beat2: got beat=%0d v=%b expected 2 1",
                         bus.data_wr_beat, bus.data_wr_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++; if (state_pend !== '0 || data_pend !== '0 || done_pend !== '0 ||
                  bus.data_wr_valid !== 1'b0 || bus.fill_done_valid !== 1'b0 || bus.fill_data_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_cleared: got %b/%b/%b dv=%b fdv=%b fdr=%b expected all 0",
                         state_pend, data_pend, done_pend, bus.data_wr_valid,
                         bus.fill_done_valid, bus.fill_data_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (bus.fill_done_valid || !bus.fill_req_ready) done_seen = 1'b1;
    end
    checks++; if (done_seen) begin
      errors++; $display("[TB] FAIL midrst_idle: got done/not-ready after reset expected idle");
    end
    @(negedge clk);
    bus.fill_data_valid = 1'b0;
    applyStimulus(2'd0, 9'd1, 24'h000042, 2'd2);
    @(negedge clk);
    bus.fill_req_valid = 1'b0;
    #1;
    checks++; if (bus.tag_wr_valid !== 1'b1 || bus.tag_wr_way !== 2'd0 || state_pend !== 4'b0001) begin
      errors++; $display("[TB] FAIL midrst_new_tag: got tv=%b w=%0d sp=%b expected 1 0 0001",
                         bus.tag_wr_valid, bus.tag_wr_way, state_pend);
    end
    run_to_idle(ok, dway);
    checks++; if (!ok || dway !== 2'd0 || done_pend !== 4'b0001) begin
      errors++; $display("[TB] FAIL midrst_new_done: got seen=%b way=%0d np=%b expected 1 0 0001",
                         ok, dway, done_pend);
    end
  endtask

  task automatic test_random_stalls();
    bit                 act;
    bit                 tdone;
    bit                 err_e;
    int                 beats;
    logic [WAY_W-1:0]   mw;
    logic [SET_W-1:0]   mi;
    logic [TAG_W-1:0]   mt;
    logic [STATE_W-1:0] ms;
    bit e_tv, e_dphase, e_dv, e_dr, e_done;
    logic [N_WAYS-1:0] e_sp, e_dp, e_np;
    act = 1'b0; tdone = 1'b0; err_e = 1'b0; beats = 0;
    mw = '0; mi = '0; mt = '0; ms = '0;
    @(negedge clk);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      bus.fill_req_valid  = ($urandom_range(0, 2) == 0);
      bus.fill_req_way    = WAY_W'($urandom());
      bus.fill_req_index  = SET_W'($urandom());
      bus.fill_req_tag    = TAG_W'($urandom());
      bus.fill_req_state  = STATE_W'($urandom());
      bus.tag_wr_ready    = 1'($urandom());
      bus.fill_data_valid = 1'($urandom());
      bus.fill_data       = rand_data();
      bus.data_wr_ready   = 1'($urandom());
      bus.fill_done_ready = 1'($urandom());
      #1;
      e_tv     = act && !tdone;
      e_dphase = act && tdone && (beats < N_BEATS);
      e_dv     = e_dphase && bus.fill_data_valid;
      e_dr     = e_dphase && bus.data_wr_ready;
      e_done   = act && (beats == N_BEATS);
      e_sp     = e_tv ? onehot(mw) : '0;
      e_dp     = (act && beats < N_BEATS) ? onehot(mw) : '0;
      e_np     = e_done ? onehot(mw) : '0;

      checks++; if (bus.fill_req_ready !== !act || bus.tag_wr_valid !== e_tv || bus.data_wr_valid !== e_dv ||
                    bus.fill_data_ready !== e_dr || bus.fill_done_valid !== e_done) begin
        errors++; $display("[TB] FAIL rand_handshake cyc%0d: got rdy=%b tv=%b dv=%b dr=%b nv=%b expected %b %b %b %b %b",
                           cyc, bus.fill_req_ready, bus.tag_wr_valid, bus.data_wr_valid, bus.fill_data_ready,
                           bus.fill_done_valid, !act, e_tv, e_dv, e_dr, e_done);
      end
      checks++; if (state_pend !== e_sp || data_pend !== e_dp || done_pend !== e_np) begin
        errors++; $display("[TB] FAIL rand_flags cyc%0d: got %b/%b/%b expected %b/%b/%b",
                           cyc, state_pend, data_pend, done_pend, e_sp, e_dp, e_np);
      end
      checks++; if (fill_err !== err_e) begin
        errors++; $display("[TB] FAIL rand_err cyc%0d: got %b expected %b", cyc, fill_err, err_e);
      end
      checks++; if ((data_pend & done_pend) !== '0 || (state_pend & ~data_pend) !== '0 ||
                    $countones(state_pend | data_pend | done_pend) > 1) begin
        errors++; $display("[TB] FAIL rand_invariant cyc%0d: got %b/%b/%b expected exclusive one-way flags",
                           cyc, state_pend, data_pend, done_pend);
      end
      if (e_tv) begin
        checks++; if (bus.tag_wr_way !== mw || bus.tag_wr_index !== mi || bus.tag_wr_tag !== mt || bus.tag_wr_state !== ms) begin
          errors++; $display("[TB] FAIL rand_tag_payload cyc%0d: got w=%0d i=%0d t=%h s=%0d expected w=%0d i=%0d t=%h s=%0d",
                             cyc, bus.tag_wr_way, bus.tag_wr_index, bus.tag_wr_tag, bus.tag_wr_state, mw, mi, mt, ms);
        end
      end
      if (e_dv) begin
        checks++; if (bus.data_wr_beat !== BEAT_W'(beats) || bus.data_wr_data !== bus.fill_data ||
                      bus.data_wr_way !== mw || bus.data_wr_index !== mi) begin
          errors++; $display("[TB] FAIL rand_data_payload cyc%0d: got beat=%0d w=%0d i=%0d expected beat=%0d w=%0d i=%0d",
                             cyc, bus.data_wr_beat, bus.data_wr_way, bus.data_wr_index, beats, mw, mi);
        end
      end
      if (e_done) begin
        checks++; if (bus.fill_done_way !== mw) begin
          errors++; $display("[TB] FAIL rand_done_way cyc%0d: got %0d expected %0d", cyc, bus.fill_done_way, mw);
        end
      end

      err_e = 1'b0;
      if (!act && bus.fill_req_valid) begin
        if (bus.fill_req_state != '0) begin
          act = 1'b1; tdone = 1'b0; beats = 0;
          mw = bus.fill_req_way; mi = bus.fill_req_index;
          mt = bus.fill_req_tag; ms = bus.fill_req_state;
        end else begin
          err_e = 1'b1;
        end
      end else if (e_tv && bus.tag_wr_ready) begin
        tdone = 1'b1;
      end else if (e_dv && bus.data_wr_ready) begin
        beats++;
      end else if (e_done && bus.fill_done_ready) begin
        act = 1'b0;
      end
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_fill();
    test_tag_stall();
    test_reject();
    test_data_toggle();
    test_reset_mid_fill();
    test_random_stalls();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ccp_fill_ctrl.md
CCP_FILL_CTRL -- requirements
Module: ccp_fill_ctrl

Interface
REQ-001 SHALL have parameter N_WAYS, default 4, number of cache ways; WAY_W = $clog2(N_WAYS).
REQ-002 SHALL have parameter SET_W, default 9, set-index width.
REQ-003 SHALL have parameter TAG_W, default 24, tag width.
REQ-004 SHALL have parameter STATE_W, default 2, line-state width; value 0 means invalid.
REQ-005 SHALL have parameter N_BEATS, default 4, data beats per line (power of two, at least 2); BEAT_W = $clog2(N_BEATS).
REQ-006 SHALL have parameter DATA_W, default 128, beat width.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 fill_req_valid/fill_req_ready  in/out  1/1  fill request handshake.
REQ-010 fill_req_way, fill_req_index, fill_req_tag, fill_req_state  in  WAY_W/SET_W/TAG_W/STATE_W  fill target and new line state.
REQ-011 tag_wr_valid/tag_wr_ready  out/in  1/1  tag array write handshake.
REQ-012 tag_wr_way, tag_wr_index, tag_wr_tag, tag_wr_state  out  WAY_W/SET_W/TAG_W/STATE_W  tag array write payload.
REQ-013 fill_data_valid/fill_data_ready  in/out  1/1  incoming fill data beat handshake; fill_data  in  DATA_W.
REQ-014 data_wr_valid/data_wr_ready  out/in  1/1  data array write handshake.
REQ-015 data_wr_way, data_wr_index, data_wr_beat, data_wr_data  out  WAY_W/SET_W/BEAT_W/DATA_W  data array write payload.
REQ-016 fill_done_valid/fill_done_ready  out/in  1/1  fill-complete handshake; fill_done_way  out  WAY_W.
REQ-017 fill_state_pending, fill_data_pending, fill_done_pending  out  N_WAYS each  per-way pending flags.
REQ-018 fill_err  out  1  one-cycle pulse for a rejected request.

Function
REQ-019 SHALL implement FSM states IDLE, TAG_WR, DATA, DONE; one fill in flight.
REQ-020 fill_req_ready SHALL equal (state == IDLE); all other handshake readies and valids SHALL be 0 outside their own state.
REQ-021 On accept with fill_req_state != 0: latch way/index/tag/state, set fill_state_pending[way] and fill_data_pending[way], clear beat counter, go to TAG_WR.
REQ-022 On accept with fill_req_state == 0: pulse fill_err next cycle, change no pending flag, stay IDLE.
REQ-023 TAG_WR: tag_wr_valid=1 with latched payload held stable until tag_wr_ready; on handshake clear fill_state_pending[way], go to DATA.
REQ-024 DATA: data_wr_valid = fill_data_valid; fill_data_ready = data_wr_ready; data_wr_data = fill_data; data_wr_beat = beat counter; combinational pass-through, zero added latency.
REQ-025 Each DATA beat handshake SHALL increment the beat counter; the handshake at beat N_BEATS-1 SHALL clear fill_data_pending[way], set fill_done_pending[way] and go to DONE; the counter wraps to 0.
REQ-026 DONE: fill_done_valid=1, fill_done_way = latched way, held until fill_done_ready; on handshake clear fill_done_pending[way], go to IDLE.
REQ-027 No cycle SHALL show fill_data_pending[w] and fill_done_pending[w] both set; at most one way SHALL have any pending bit set.
REQ-028 fill_state_pending[w] set SHALL imply fill_data_pending[w] set.
REQ-029 Stalls (ready low) in any state SHALL not change the payload, counter or flags.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE, beat counter 0, all pending flags 0, fill_err 0, all output valids 0; fill_req_ready SHALL be 1 from the first clock edge after release.
REQ-031 Reset mid-fill SHALL abandon the fill with no done handshake; the latched payload need not be cleared.

Verification
REQ-032 Way 2, index 5, tag 0xABC, state 1, all readies 1 -> tag write 1 cycle after accept, 4 beats (indices 0-3) on consecutive cycles, fill_done_valid with way 2; accept-to-done-handshake = 6 cycles.
REQ-033 tag_wr_ready held low 3 cycles -> payload stable, fill_state_pending[2]=1 throughout, fill_req_ready=0.
REQ-034 fill_req_state=0 -> fill_err pulses 1 cycle, pending flags remain 0, next request accepted.
REQ-035 data_wr_ready toggling 1,0,1,0 -> beats 0..3 issued in order, none dropped or duplicated, data_pending clears only on beat 3.
REQ-036 reset_n asserted during DATA beat 2 -> all flags 0, IDLE, no fill_done_valid; new fill to way 0 completes normally.
REQ-037 Random stall stimulus -> REQ-027/REQ-028 invariants hold every cycle.
